text_serializer: RTL and testbench
==================================

// Module: text_serializer
// PURPOSE
//  Downstream of the text-fetch stage. Takes message bytes over a valid/ready handshake and emits
//  one serial frame: SYNC_WORD, then FRAME_BYTES bytes MSB-first, each followed by an even-parity bit.
//  Each bit is held for BIT_PERIOD clocks. Feeds the line-coding/modulator stage.
// PARAMETERS
//  BIT_PERIOD   4      clocks per transmitted bit (>=1)
//  FRAME_BYTES  256    payload bytes per frame (1..256)
//  SYNC_WORD    8'h7E  frame-start pattern, sent MSB-first, no parity bit
// PORTS
//  clk           in   1  single system clock, all logic on rising edge
//  reset_n       in   1  asynchronous, active-low reset
//  start_source  in   1  1-cycle pulse: begin a frame (ignored unless IDLE)
//  byte_in       in   8  payload byte from the fetch stage
//  byte_valid    in   1  byte_in is valid
//  byte_ready    out  1  byte accepted on a cycle with byte_valid && byte_ready
//  bit_out       out  1  serial line; idle level 1
//  bit_strobe    out  1  high on the first clock of each new bit
//  frame_active  out  1  high from SYNC through the last parity bit
//  frame_done    out  1  1-cycle pulse after the last parity bit's final clock
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, bit_out=1, byte_ready=0, bit_strobe=0,
//   frame_active=0, frame_done=0, byte counter=0, bit-period counter=0, shift reg=0.
//  States: IDLE -> SYNC -> LOAD -> DATA -> PARITY -> (LOAD | DONE) -> IDLE.
//  IDLE: bit_out=1. start_source=1 -> SYNC next cycle. start_source outside IDLE is ignored.
//  SYNC: 8 bits of SYNC_WORD, MSB first, each held BIT_PERIOD clocks -> LOAD.
//  LOAD: byte_ready=1 (combinational on state==LOAD). On valid&&ready, capture byte_in,
//   clear parity accumulator -> DATA next cycle. No valid: stay in LOAD, bit_out=1,
//   bit_strobe=0 (underrun stall, no timeout). Exactly one byte accepted per LOAD visit.
//  DATA: shift out 8 bits MSB first; parity accumulates XOR of the bits -> PARITY.
//  PARITY: one bit = XOR of the 8 data bits (even parity). Byte counter+1; if counter reaches
//   FRAME_BYTES -> DONE, else -> LOAD.
//  DONE: frame_done=1 for one cycle, frame_active=0, counter cleared -> IDLE.
//  Timing: start_source seen in IDLE at edge N -> bit_out=SYNC_WORD[7], bit_strobe=1,
//   frame_active=1 from edge N+1. Each bit is exactly BIT_PERIOD clocks. Each LOAD costs
//   at least 1 clock, line held at 1 during that clock.
//  All outputs are registered, except byte_ready, which is decoded from state.
//  Bit-period counter counts 0..BIT_PERIOD-1 and wraps. Bit index 3 bits, 7->0 wrap ends byte.
//  Byte counter width $clog2(FRAME_BYTES+1), so 256 is representable. No overflow past FRAME_BYTES.
//  reset_n deasserted mid-frame: immediate return to reset values. The partial frame is abandoned.
//   No frame_done is issued. The next frame needs a fresh start_source.
//  byte_valid high outside LOAD: no effect. byte_in is sampled only on the accept cycle.
// STRUCTURE
//  Shared include text_tx_defs.vh:
//   - state encodings (IDLE, SYNC, LOAD, DATA, PARITY, DONE)
//   - IDLE_LEVEL=1'b1
//   - default SYNC_WORD
//  Sub-module bit_timer: BIT_PERIOD counter with enable and sync clear.
//   - outputs tick_first (bit start) and tick_last (bit end)
//   - cleared in IDLE/LOAD
// TESTING
//  1 Reset: reset_n=0 for 3 clks mid-DATA -> bit_out=1, outputs 0, state IDLE; no frame_done.
//  2 FRAME_BYTES=2, BIT_PERIOD=4, bytes 8'hA5, 8'h01 always valid -> per bit:
//     SYNC 0,1,1,1,1,1,1,0; A5 bits 1,0,1,0,0,1,0,1, parity 0; 01 bits 0,0,0,0,0,0,0,1,
//     parity 1; each bit 4 clks; frame_done one cycle after the last parity bit.
//  3 Underrun: hold byte_valid=0 for 10 clks in LOAD -> bit_out=1, bit_strobe=0,
//     byte_ready=1 throughout; on valid, DATA starts the next cycle.
//  4 start_source pulsed during DATA -> ignored; exactly FRAME_BYTES bytes accepted,
//     one frame_done.
//  5 BIT_PERIOD=1, FRAME_BYTES=256, counting data 0..255 -> 256 accepts.
//     Scoreboard checks every byte and parity; frame_done once; byte counter does not wrap.

Source files
------------

// File: rtl/text_serializer_pkg.sv
// Shared definitions for the serial frame transmitter: FSM encodings and line constants.
package text_serializer_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_SYNC   = 3'd1;
  localparam state_t ST_LOAD   = 3'd2;
  localparam state_t ST_DATA   = 3'd3;
  localparam state_t ST_PARITY = 3'd4;
  localparam state_t ST_DONE   = 3'd5;

  localparam logic       IDLE_LEVEL        = 1'b1;
  localparam logic [7:0] DEFAULT_SYNC_WORD = 8'h7E;

endpackage

// File: rtl/text_serializer_bit_timer.sv
// Bit-period counter: counts 0..BIT_PERIOD-1 while enabled, flags the first and last clock
// of each bit.
module text_serializer_bit_timer #(
  parameter int unsigned BIT_PERIOD = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick_first,
  output logic o_tick_last
);

  localparam int unsigned    CntW    = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(BIT_PERIOD - 1);

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_next;

  always_comb begin
    w_cnt_next = r_cnt;
    if (i_clr) begin
      w_cnt_next = '0;
    end else if (i_en) begin
      w_cnt_next = (r_cnt == LastCnt) ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign o_tick_first = i_en && (r_cnt == '0);
  assign o_tick_last  = i_en && (r_cnt == LastCnt);

endmodule

// File: rtl/text_serializer.sv
// Serial frame transmitter: sync word, then FRAME_BYTES bytes MSB-first with even parity.
// Line outputs are registered one cycle behind the FSM; byte_ready is decoded from state.
module text_serializer
  import text_serializer_pkg::*;
#(
  parameter int unsigned BIT_PERIOD  = 4,
  parameter int unsigned FRAME_BYTES = 256,
  parameter logic [7:0]  SYNC_WORD   = DEFAULT_SYNC_WORD
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_source,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       bit_out,
  output logic       bit_strobe,
  output logic       frame_active,
  output logic       frame_done
);

  localparam int unsigned         ByteCntW = $clog2(FRAME_BYTES + 1);
  localparam logic [ByteCntW-1:0] LastByte = ByteCntW'(FRAME_BYTES);

  state_t              r_state, w_state_next;
  logic [7:0]          r_shift, w_shift_next;
  logic [2:0]          r_bit_idx, w_bit_idx_next;
  logic                r_parity, w_parity_next;
  logic [ByteCntW-1:0] r_byte_cnt, w_byte_cnt_next, w_byte_cnt_inc;

  logic w_timer_en, w_timer_clr, w_tick_first, w_tick_last;
  logic w_bit, w_active, w_done;
  logic r_bit_out, r_bit_strobe, r_frame_active, r_frame_done;

  assign w_timer_en  = (r_state == ST_SYNC) || (r_state == ST_DATA) || (r_state == ST_PARITY);
  assign w_timer_clr = !w_timer_en;

  text_serializer_bit_timer #(
    .BIT_PERIOD (BIT_PERIOD)
  ) u_bit_timer (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_en         (w_timer_en),
    .i_clr        (w_timer_clr),
    .o_tick_first (w_tick_first),
    .o_tick_last  (w_tick_last)
  );

  assign w_byte_cnt_inc = r_byte_cnt + ByteCntW'(1);

  always_comb begin
    w_state_next    = r_state;
    w_shift_next    = r_shift;
    w_bit_idx_next  = r_bit_idx;
    w_parity_next   = r_parity;
    w_byte_cnt_next = r_byte_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (start_source) begin
          w_state_next   = ST_SYNC;
          w_shift_next   = SYNC_WORD;
          w_bit_idx_next = '0;
        end
      end
      ST_SYNC: begin
        if (w_tick_last) begin
          w_shift_next   = {r_shift[6:0], 1'b0};
          w_bit_idx_next = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (byte_valid) begin
          w_state_next   = ST_DATA;
          w_shift_next   = byte_in;
          w_parity_next  = 1'b0;
          w_bit_idx_next = '0;
        end
      end
      ST_DATA: begin
        if (w_tick_last) begin
          w_parity_next  = r_parity ^ r_shift[7];
          w_shift_next   = {r_shift[6:0], 1'b0};
          w_bit_idx_next = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state_next = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (w_tick_last) begin
          w_byte_cnt_next = w_byte_cnt_inc;
          w_state_next    = (w_byte_cnt_inc == LastByte) ? ST_DONE : ST_LOAD;
        end
      end
      ST_DONE: begin
        w_byte_cnt_next = '0;
        w_state_next    = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Line level for the current FSM cycle; registered below to form the outputs.
  always_comb begin
    w_bit = IDLE_LEVEL;
    unique case (r_state)
      ST_SYNC, ST_DATA: w_bit = r_shift[7];
      ST_PARITY:        w_bit = r_parity;
      default:          w_bit = IDLE_LEVEL;
    endcase
  end

  assign w_active = (r_state == ST_SYNC) || (r_state == ST_LOAD) ||
                    (r_state == ST_DATA) || (r_state == ST_PARITY);
  assign w_done   = (r_state == ST_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_shift        <= '0;
      r_bit_idx      <= '0;
      r_parity       <= 1'b0;
      r_byte_cnt     <= '0;
      r_bit_out      <= IDLE_LEVEL;
      r_bit_strobe   <= 1'b0;
      r_frame_active <= 1'b0;
      r_frame_done   <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_shift        <= w_shift_next;
      r_bit_idx      <= w_bit_idx_next;
      r_parity       <= w_parity_next;
      r_byte_cnt     <= w_byte_cnt_next;
      r_bit_out      <= w_bit;
      r_bit_strobe   <= w_tick_first;
      r_frame_active <= w_active;
      r_frame_done   <= w_done;
    end
  end

  assign byte_ready   = (r_state == ST_LOAD);
  assign bit_out      = r_bit_out;
  assign bit_strobe   = r_bit_strobe;
  assign frame_active = r_frame_active;
  assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_text_serializer.sv
// Directed bench: dut_a (BIT_PERIOD=4, FRAME_BYTES=2) for frame/underrun/reset cases,
// dut_b (BIT_PERIOD=1, FRAME_BYTES=256) for a full counting-data frame.
module tb_text_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic       a_start, a_valid, a_ready, a_bit, a_strobe, a_active, a_done;
  logic [7:0] a_byte;
  logic       b_start, b_valid, b_ready, b_bit, b_strobe, b_active, b_done;
  logic [7:0] b_byte;

  text_serializer #(.BIT_PERIOD(4), .FRAME_BYTES(2), .SYNC_WORD(8'h7E)) dut_a (
    .clk(clk), .reset_n(reset_n), .start_source(a_start), .byte_in(a_byte),
    .byte_valid(a_valid), .byte_ready(a_ready), .bit_out(a_bit), .bit_strobe(a_strobe),
    .frame_active(a_active), .frame_done(a_done)
  );

  text_serializer #(.BIT_PERIOD(1), .FRAME_BYTES(256), .SYNC_WORD(8'h7E)) dut_b (
    .clk(clk), .reset_n(reset_n), .start_source(b_start), .byte_in(b_byte),
    .byte_valid(b_valid), .byte_ready(b_ready), .bit_out(b_bit), .bit_strobe(b_strobe),
    .frame_active(b_active), .frame_done(b_done)
  );

  typedef struct { logic exp_bit; int exp_gap; } bit_vec_t;
  typedef struct { logic [7:0] data; logic exp_par; } byte_vec_t;

  bit_vec_t  frame_tab [26];
  byte_vec_t byte_tab  [4];

  int n_tests, n_fail;

  // Byte sources and monitor state.
  logic [7:0] a_src [0:3];
  int   a_len, a_ptr, b_ptr;
  logic a_feed_en, b_feed_en, a_acc, b_acc;
  logic a_bits[$], b_bits[$];
  int   a_scyc[$], b_scyc[$];
  int   cyc, a_done_cnt, b_done_cnt, a_done_cyc, b_done_cyc, a_acc_cnt, b_acc_cnt;
  int   a_hold_err, a_last_scyc;
  logic a_last_bit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_a();
    a_bits.delete(); a_scyc.delete();
    a_done_cnt = 0; a_acc_cnt = 0; a_hold_err = 0; a_last_scyc = -100;
  endtask

  task automatic pulse_a();
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
  endtask

  task automatic wait_done_a(input string name, input int budget);
    int n = 0;
    while (a_done_cnt < 1 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(name, (a_done_cnt >= 1), 1);
  endtask

  task automatic check_payload(input int base);
    check("payload_len", a_bits.size(), 26);
    if (a_bits.size() == 26) begin
      for (int b = 0; b < 2; b++) begin
        logic [7:0] got = '0;
        for (int j = 0; j < 8; j++) got = {got[6:0], a_bits[8 + 9*b + j]};
        check($sformatf("byte%0d_data", base + b), got, byte_tab[base + b].data);
        check($sformatf("byte%0d_par", base + b), a_bits[16 + 9*b], byte_tab[base + b].exp_par);
      end
    end
  endtask

  // Feeders: present the next byte, advance on a handshake seen before the edge.
  initial begin
    a_valid = 1'b0; a_byte = 8'h00; b_valid = 1'b0; b_byte = 8'h00;
    forever begin
      @(negedge clk);
      a_acc = a_valid && a_ready && reset_n;
      b_acc = b_valid && b_ready && reset_n;
      @(posedge clk); #2;
      if (a_acc) a_ptr++;
      if (b_acc) b_ptr++;
      a_valid = a_feed_en && (a_ptr < a_len);
      a_byte  = a_valid ? a_src[a_ptr] : 8'h00;
      b_valid = b_feed_en && (b_ptr < 256);
      b_byte  = b_valid ? 8'(b_ptr) : 8'h00;
    end
  end

  // Monitor: capture strobed bits, done pulses and accepts; check bit hold on dut_a.
  initial begin
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (a_strobe) begin
        a_bits.push_back(a_bit); a_scyc.push_back(cyc);
        a_last_bit = a_bit; a_last_scyc = cyc;
      end else if (a_active && (cyc - a_last_scyc) < 4 && a_bit !== a_last_bit) begin
        a_hold_err++;
      end
      if (a_done) begin a_done_cnt++; a_done_cyc = cyc; end
      if (a_valid && a_ready) a_acc_cnt++;
      if (b_strobe) begin b_bits.push_back(b_bit); b_scyc.push_back(cyc); end
      if (b_done) begin b_done_cnt++; b_done_cyc = cyc; end
      if (b_valid && b_ready) b_acc_cnt++;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [25:0] frame_lit;
    int snap, n;
    n_tests = 0; n_fail = 0;
    reset_n = 1'b0; a_start = 1'b0; b_start = 1'b0;
    a_feed_en = 1'b0; b_feed_en = 1'b0; a_len = 0; a_ptr = 0; b_ptr = 0;
    b_done_cnt = 0; b_acc_cnt = 0;
    clear_a();

    // SYNC 7E, A5 + parity 0, 01 + parity 1; LOAD adds one clock before each byte.
    frame_lit = 26'b01111110_101001010_000000011;
    for (int i = 0; i < 26; i++) begin
      frame_tab[i].exp_bit = frame_lit[25 - i];
      frame_tab[i].exp_gap = (i == 8 || i == 17) ? 5 : 4;
    end
    byte_tab[0] = '{8'hC3, 1'b0};
    byte_tab[1] = '{8'h07, 1'b1};
    byte_tab[2] = '{8'h5A, 1'b0};
    byte_tab[3] = '{8'hFE, 1'b1};

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_bit", a_bit, 1); check("rst_a_strobe", a_strobe, 0);
    check("rst_a_active", a_active, 0); check("rst_a_done", a_done, 0);
    check("rst_a_ready", a_ready, 0);
    check("rst_b_bit", b_bit, 1); check("rst_b_active", b_active, 0);
    check("rst_b_ready", b_ready, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Full frame with bytes always valid.
    a_src[0] = 8'hA5; a_src[1] = 8'h01; a_len = 2; a_ptr = 0; a_feed_en = 1'b1;
    clear_a();
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    @(negedge clk);
    check("start_lat_active0", a_active, 0); check("start_lat_bit0", a_bit, 1);
    @(negedge clk);
    check("start_active", a_active, 1); check("start_strobe", a_strobe, 1);
    check("start_bit", a_bit, 0);
    wait_done_a("frame_done_seen", 400);
    repeat (3) @(posedge clk); #1;
    check("frame_nbits", a_bits.size(), 26);
    if (a_bits.size() == 26) begin
      for (int i = 0; i < 26; i++) begin
        check($sformatf("frame_bit%0d", i), a_bits[i], frame_tab[i].exp_bit);
        if (i > 0) check($sformatf("frame_gap%0d", i), a_scyc[i] - a_scyc[i-1],
                         frame_tab[i].exp_gap);
      end
      check("done_after_parity", a_done_cyc - a_scyc[25], 4);
    end
    check("frame_done_cnt", a_done_cnt, 1); check("frame_accepts", a_acc_cnt, 2);
    check("frame_hold", a_hold_err, 0); check("frame_idle_active", a_active, 0);
    check("frame_idle_bit", a_bit, 1);

    // Underrun: byte_valid low in LOAD.
    a_src[0] = byte_tab[0].data; a_src[1] = byte_tab[1].data; a_len = 2; a_ptr = 0;
    a_feed_en = 1'b0;
    clear_a();
    pulse_a();
    n = 0;
    do begin @(negedge clk); n++; end while (!a_ready && n < 100);
    check("underrun_reach_load", a_ready, 1);
    repeat (10) begin
      @(negedge clk);
      check("underrun_bit", a_bit, 1); check("underrun_strobe", a_strobe, 0);
      check("underrun_ready", a_ready, 1);
    end
    @(posedge clk); #1 a_feed_en = 1'b1;
    @(negedge clk);
    check("underrun_handshake", a_valid && a_ready, 1);
    @(negedge clk);
    check("underrun_data_next", a_ready, 0);
    @(negedge clk);
    check("underrun_first_strobe", a_strobe, 1); check("underrun_first_bit", a_bit, 1);
    wait_done_a("underrun_done_seen", 400);
    repeat (3) @(posedge clk); #1;
    check_payload(0);
    check("underrun_done_cnt", a_done_cnt, 1); check("underrun_accepts", a_acc_cnt, 2);
    check("underrun_hold", a_hold_err, 0);

    // start_source during DATA is ignored.
    a_src[0] = byte_tab[2].data; a_src[1] = byte_tab[3].data; a_len = 2; a_ptr = 0;
    clear_a();
    pulse_a();
    n = 0;
    while (a_bits.size() < 10 && n < 200) begin @(posedge clk); n++; end
    check("restart_in_data", a_bits.size() >= 10, 1);
    pulse_a();
    wait_done_a("restart_done_seen", 400);
    repeat (20) @(posedge clk); #1;
    check_payload(2);
    check("restart_done_cnt", a_done_cnt, 1); check("restart_accepts", a_acc_cnt, 2);
    check("restart_no_new_frame", a_active, 0); check("restart_ready", a_ready, 0);

    // Reset mid-DATA abandons the frame.
    a_src[0] = 8'hA5; a_src[1] = 8'h01; a_len = 2; a_ptr = 0;
    clear_a();
    pulse_a();
    n = 0;
    while (a_bits.size() < 12 && n < 200) begin @(posedge clk); n++; end
    check("rst_mid_in_data", a_bits.size() >= 12, 1);
    @(posedge clk); #1 reset_n = 1'b0;
    #1;
    check("rst_mid_bit", a_bit, 1); check("rst_mid_strobe", a_strobe, 0);
    check("rst_mid_active", a_active, 0); check("rst_mid_done", a_done, 0);
    check("rst_mid_ready", a_ready, 0);
    snap = a_bits.size();
    repeat (3) @(posedge clk);
    #1 a_ptr = 0;
    @(negedge clk); #1 reset_n = 1'b1;
    repeat (20) @(posedge clk); #1;
    check("rst_mid_no_done", a_done_cnt, 0); check("rst_mid_stays_idle", a_active, 0);
    check("rst_mid_no_bits", a_bits.size(), snap);
    clear_a();
    pulse_a();
    wait_done_a("rst_recover_done_seen", 400);
    repeat (3) @(posedge clk); #1;
    check("rst_recover_nbits", a_bits.size(), 26);
    check("rst_recover_accepts", a_acc_cnt, 2);

    // 256-byte counting frame at one clock per bit.
    b_ptr = 0; b_feed_en = 1'b1; b_bits.delete(); b_scyc.delete();
    b_done_cnt = 0; b_acc_cnt = 0;
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    n = 0;
    while (b_done_cnt < 1 && n < 5000) begin @(posedge clk); n++; end
    check("big_done_seen", (b_done_cnt >= 1), 1);
    repeat (10) @(posedge clk); #1;
    check("big_done_cnt", b_done_cnt, 1); check("big_accepts", b_acc_cnt, 256);
    check("big_nbits", b_bits.size(), 8 + 256 * 9);
    if (b_bits.size() == 8 + 256 * 9) begin
      logic [7:0] sync = '0;
      for (int j = 0; j < 8; j++) sync = {sync[6:0], b_bits[j]};
      check("big_sync", sync, 8'h7E);
      for (int k = 0; k < 256; k++) begin
        logic [7:0] got = '0;
        logic [7:0] want;
        want = 8'(k);
        for (int j = 0; j < 8; j++) got = {got[6:0], b_bits[8 + 9*k + j]};
        check($sformatf("big_data%0d", k), got, want);
        check($sformatf("big_par%0d", k), b_bits[16 + 9*k], ^want);
      end
      check("big_done_after_parity", b_done_cyc - b_scyc[8 + 256*9 - 1], 1);
    end
    check("big_idle_active", b_active, 0); check("big_idle_ready", b_ready, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
